// File: rtl/amiga_kbd_pkg.sv
// Shared types and constants for the Amiga keyboard-side serial link.
// The reserved codes are used by the power-up sequencer.
package amiga_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CLK_LO,
        CLK_HI,
        WAIT_HS,
        RESYNC
    } kbd_state_e;

    localparam logic [7:0] KBD_LOST_SYNC  = 8'hF9;
    localparam logic [7:0] KBD_INIT_BEGIN = 8'hFD;
    localparam logic [7:0] KBD_INIT_END   = 8'hFE;

    // Wire byte: keycode bits 6..0 followed by the up/down flag, sent MSB first.
    function automatic logic [7:0] kbd_frame(input logic [6:0] code, input logic up);
        return {code, up};
    endfunction

endpackage

// File: rtl/amiga_kbd_sync.sv
// KDAT input synchronizer plus low-run length counter; hs_ok flags the end
// of a low run that was long enough to count as a host handshake.
module amiga_kbd_sync #(
    parameter int HS_MIN_CYC = 75
) (
    input  logic CLK_2,
    input  logic _RES,
    input  logic kdat_in,
    input  logic arm,
    output logic hs_ok
);

    localparam int RUN_W = $clog2(HS_MIN_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HS_MIN_CYC);

    logic             s1;
    logic             s2;
    logic [RUN_W-1:0] run_len;

    // Run length saturates at the threshold; disarming drops any partial run.
    always_ff @(posedge CLK_2 or negedge _RES) begin
        if (!_RES) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            run_len <= '0;
        end else begin
            s1 <= kdat_in;
            s2 <= s1;
            if (!arm || s2)
                run_len <= '0;
            else if (run_len != RUN_MAX)
                run_len <= run_len + 1'b1;
        end
    end

    assign hs_ok = arm && s2 && (run_len == RUN_MAX);

endmodule

// File: rtl/amiga_kbd_tx.sv
// Keyboard-side Amiga KDAT/KCLK transmitter with host handshake wait and
// lost-sync recovery (one extra '1' bit per timeout, then resend).
module amiga_kbd_tx
    import amiga_kbd_pkg::*;
#(
    parameter int BIT_CYC    = 20,
    parameter int HS_MIN_CYC = 75,
    parameter int HS_TMO_CYC = 143000,
    parameter int CNT_W      = 18
) (
    input  logic       CLK_2,
    input  logic       _RES,
    input  logic       key_valid,
    input  logic [6:0] key_code,
    input  logic       key_up,
    output logic       key_ready,
    output logic       kdat_oe,
    input  logic       kdat_in,
    output logic       kclk_oe,
    output logic [3:0] resync_cnt
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(HS_TMO_CYC - 1);

    kbd_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       frame;
    logic [2:0]       bit_idx;
    logic [2:0]       nxt_idx;
    logic             in_rs;
    logic             retx;
    logic             hs_ok;

    assign nxt_idx = bit_idx + 3'd1;

    amiga_kbd_sync #(
        .HS_MIN_CYC(HS_MIN_CYC)
    ) u_sync (
        .CLK_2  (CLK_2),
        ._RES   (_RES),
        .kdat_in(kdat_in),
        .arm    (state == WAIT_HS),
        .hs_ok  (hs_ok)
    );

    always_ff @(posedge CLK_2 or negedge _RES) begin
        if (!_RES) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            in_rs      <= 1'b0;
            retx       <= 1'b0;
            key_ready  <= 1'b1;
            kdat_oe    <= 1'b0;
            kclk_oe    <= 1'b0;
            resync_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        frame     <= kbd_frame(key_code, key_up);
                        bit_idx   <= '0;
                        kdat_oe   <= key_code[6];
                        key_ready <= 1'b0;
                        in_rs     <= 1'b0;
                        retx      <= 1'b0;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                // RESYNC is the data-setup phase of the single recovery bit.
                SETUP, RESYNC: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        kclk_oe <= 1'b1;
                        state   <= CLK_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLK_LO: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        kclk_oe <= 1'b0;
                        state   <= CLK_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLK_HI: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (in_rs) begin
                            in_rs   <= 1'b0;
                            retx    <= 1'b1;
                            kdat_oe <= 1'b0;
                            if (resync_cnt != 4'hF)
                                resync_cnt <= resync_cnt + 4'd1;
                            state   <= WAIT_HS;
                        end else if (bit_idx == 3'd7) begin
                            kdat_oe <= 1'b0;
                            state   <= WAIT_HS;
                        end else begin
                            bit_idx <= nxt_idx;
                            kdat_oe <= frame[3'd7 - nxt_idx];
                            state   <= SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HS: begin
                    if (hs_ok) begin
                        cnt <= '0;
                        if (retx) begin
                            retx    <= 1'b0;
                            bit_idx <= '0;
                            kdat_oe <= frame[7];
                            state   <= SETUP;
                        end else begin
                            key_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (cnt == TMO_LAST) begin
                        cnt     <= '0;
                        in_rs   <= 1'b1;
                        kdat_oe <= 1'b1;
                        state   <= RESYNC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    kdat_oe <= 1'b0;
                    kclk_oe <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amiga_kbd_tx.sv
// Directed bench for amiga_kbd_tx: frame shape, handshake, resync/resend,
// mid-frame reset and held key_valid during a transfer.
module tb_amiga_kbd_tx;

    localparam int BIT_CYC    = 4;
    localparam int HS_MIN_CYC = 6;
    localparam int HS_TMO_CYC = 200;

    logic       CLK_2 = 1'b0;
    logic       res_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [6:0] key_code = '0;
    logic       key_up = 1'b0;
    logic       key_ready;
    logic       kdat_oe;
    logic       kdat_in;
    logic       kclk_oe;
    logic [3:0] resync_cnt;
    logic       host_low = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc    = 0;

    // Open-drain wire: either end may pull KDAT low.
    assign kdat_in = ~(host_low | kdat_oe);

    always #5 CLK_2 = ~CLK_2;
    always @(posedge CLK_2) cyc++;

    amiga_kbd_tx #(
        .BIT_CYC   (BIT_CYC),
        .HS_MIN_CYC(HS_MIN_CYC),
        .HS_TMO_CYC(HS_TMO_CYC),
        .CNT_W     (18)
    ) dut (
        .CLK_2     (CLK_2),
        ._RES      (res_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_up    (key_up),
        .key_ready (key_ready),
        .kdat_oe   (kdat_oe),
        .kdat_in   (kdat_in),
        .kclk_oe   (kclk_oe),
        .resync_cnt(resync_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a key for one accept edge; optionally keep key_valid asserted.
    task automatic send(input logic [6:0] c, input logic u, input bit hold);
        key_valid = 1'b1;
        key_code  = c;
        key_up    = u;
        @(negedge CLK_2);
        acc = cyc;
        if (!hold) key_valid = 1'b0;
        chk("accept_ready_low", key_ready, 1'b0);
    endtask

    // Collect bits at kclk_oe rise, count pulses, flag wrong low width or
    // data changing under a clock pulse, count cycles with key_ready high.
    task automatic watch(input int n, output logic [7:0] bits, output int pulses,
                         output int bad, output int rdy);
        logic prev;
        logic dat;
        int   lo;
        bits = '0; pulses = 0; bad = 0; rdy = 0; lo = 0;
        prev = kclk_oe; dat = kdat_oe;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_2);
            if (key_ready) rdy++;
            if (kclk_oe) begin
                if (!prev) begin
                    pulses++;
                    bits = {bits[6:0], kdat_oe};
                    dat  = kdat_oe;
                    lo   = 0;
                end else if (kdat_oe != dat) begin
                    bad++;
                end
                lo++;
            end else if (prev && lo != BIT_CYC) begin
                bad++;
            end
            prev = kclk_oe;
        end
    endtask

    task automatic handshake(input int n);
        host_low = 1'b1;
        repeat (n) @(negedge CLK_2);
        host_low = 1'b0;
    endtask

    task automatic wait_ready(output int got);
        got = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_2);
            if (key_ready) begin
                got = 1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] bits;
        int pulses, bad, rdy, got, rise, rises;
        logic prev;

        // Reset state
        repeat (3) @(negedge CLK_2);
        chk("rst_kdat", kdat_oe, 1'b0);
        chk("rst_kclk", kclk_oe, 1'b0);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_resync", resync_cnt, 4'd0);
        res_n = 1'b1;
        @(negedge CLK_2);

        // Basic frame 7'h45 down -> 8'h8A, then a good handshake
        send(7'h45, 1'b0, 1'b0);
        watch(100, bits, pulses, bad, rdy);
        chk("f1_bits", bits, 8'h8A);
        chk("f1_pulses", pulses, 8);
        chk("f1_shape", bad, 0);
        chk("f1_ready_low", rdy, 0);
        chk("f1_kdat_released", kdat_oe, 1'b0);
        handshake(8);
        wait_ready(got);
        chk("f1_hs_ready", got, 1);
        chk("f1_resync", resync_cnt, 4'd0);

        // Short glitch ignored; timeout produces one recovery bit
        send(7'h45, 1'b0, 1'b0);
        watch(100, bits, pulses, bad, rdy);
        chk("f2_bits", bits, 8'h8A);
        handshake(3);
        rise = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK_2);
            if (kclk_oe) begin
                rise = cyc - acc;
                break;
            end
        end
        chk("rs_pulse_time", rise, 300);
        chk("rs_pulse_kdat", kdat_oe, 1'b1);
        chk("rs_ready_low", key_ready, 1'b0);
        repeat (12) @(negedge CLK_2);
        chk("rs_count", resync_cnt, 4'd1);
        chk("rs_kdat_released", kdat_oe, 1'b0);
        chk("rs_kclk_released", kclk_oe, 1'b0);

        // Handshake after resync resends the byte; the next one frees the link
        handshake(8);
        watch(100, bits, pulses, bad, rdy);
        chk("retx_bits", bits, 8'h8A);
        chk("retx_pulses", pulses, 8);
        chk("retx_shape", bad, 0);
        chk("retx_ready_low", rdy, 0);
        handshake(8);
        wait_ready(got);
        chk("retx_hs_ready", got, 1);
        chk("retx_resync", resync_cnt, 4'd1);

        // Reset during CLK_LO of bit 3 (byte 8'hFF so KDAT is pulled there)
        send(7'h7F, 1'b1, 1'b0);
        rises = 0;
        prev  = kclk_oe;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_2);
            if (kclk_oe && !prev) rises++;
            prev = kclk_oe;
            if (rises == 4) break;
        end
        chk("b3_kclk", kclk_oe, 1'b1);
        chk("b3_kdat", kdat_oe, 1'b1);
        #1 res_n = 1'b0;
        #1;
        chk("arst_kclk", kclk_oe, 1'b0);
        chk("arst_kdat", kdat_oe, 1'b0);
        chk("arst_ready", key_ready, 1'b1);
        chk("arst_resync", resync_cnt, 4'd0);
        @(negedge CLK_2);
        res_n = 1'b1;
        watch(40, bits, pulses, bad, rdy);
        chk("arst_no_retx", pulses, 0);
        chk("arst_idle_ready", rdy, 40);

        // New key accepted; key_valid held with another code during the frame
        send(7'h12, 1'b1, 1'b1);
        key_code = 7'h33;
        key_up   = 1'b0;
        watch(99, bits, pulses, bad, rdy);
        chk("f3_bits", bits, 8'h25);
        chk("f3_pulses", pulses, 8);
        chk("f3_shape", bad, 0);
        handshake(8);
        wait_ready(got);
        chk("f3_hs_ready", got, 1);
        @(negedge CLK_2);
        chk("held_accept", key_ready, 1'b0);
        key_valid = 1'b0;
        watch(99, bits, pulses, bad, rdy);
        chk("f4_bits", bits, 8'h66);
        chk("f4_pulses", pulses, 8);
        handshake(8);
        wait_ready(got);
        chk("f4_hs_ready", got, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/amiga_kbd_tx.md
Name: amiga_kbd_tx

Overview:
- Keyboard-side serial transmitter for the Amiga keyboard link, the far end of the CIA-A SP/CNT serial port.
- Takes 7-bit keycodes plus an up/down flag and shifts them out over open-drain KDAT/KCLK with Amiga bit order and timing.
- Waits for the host's KDAT handshake pulse, and on handshake timeout runs the lost-sync recovery and retransmits.
- Sits between the keyboard matrix scanner and the off-chip KDAT/KCLK pads.

Parameters:
- BIT_CYC, 20, clock cycles per bit phase (20 us at 1 MHz CLK_2).
- HS_MIN_CYC, 75, minimum host KDAT-low duration accepted as a handshake.
- HS_TMO_CYC, 143000, cycles to wait for a handshake before resync (143 ms).
- CNT_W, 18, width of the shared phase/timeout counter; must hold HS_TMO_CYC.

Ports:
- CLK_2  input  1  system clock.
- _RES  input  1  asynchronous active-low reset.
- key_valid  input  1  scanner offers a key event this cycle.
- key_code  input  7  raw keycode.
- key_up  input  1  1 = key released, 0 = pressed.
- key_ready  output  1  transmitter idle; key_valid accepted when both are high.
- kdat_oe  output  1  1 = pull KDAT low.
- kdat_in  input  1  KDAT pad level, asynchronous.
- kclk_oe  output  1  1 = pull KCLK low.
- resync_cnt  output  4  saturating count of handshake timeouts.

Behaviour:
- Reset (async, _RES low): kdat_oe=0, kclk_oe=0, key_ready=1, resync_cnt=0, state IDLE, counter 0. A reset mid-frame releases both lines immediately; the frame is abandoned and not retransmitted.
- kdat_in passes through a 2-flop synchronizer. Handshake detection sees it 2 cycles late.
- Frame byte is {key_code[6:0], key_up}, sent MSB first. Wire order is therefore 6,5,4,3,2,1,0,up.
- Signalling is active-low: bit value 1 gives kdat_oe=1.
- Accept: in IDLE, key_valid & key_ready latches the byte and drops key_ready the next cycle. key_valid while busy is ignored; the scanner must hold it.
- States:
  - IDLE: ready; both lines released.
  - SETUP: drive kdat_oe for the current bit; hold BIT_CYC cycles.
  - CLK_LO: kclk_oe=1; hold BIT_CYC.
  - CLK_HI: kclk_oe=0; hold BIT_CYC. Then advance the bit index (0..7) and go to SETUP. After bit 7, release KDAT and go to WAIT_HS.
  - WAIT_HS: counter runs from entry. A synced kdat_in low run of at least HS_MIN_CYC, followed by release, goes to IDLE. Shorter low glitches are ignored, and the timeout counter keeps running through them. If the counter reaches HS_TMO_CYC with no valid handshake, go to RESYNC; a low run still in progress is abandoned.
  - RESYNC: clock out one '1' bit (SETUP/CLK_LO/CLK_HI timing, kdat_oe=1), increment resync_cnt (saturate at 15), return to WAIT_HS with a fresh timeout. A valid handshake reached via resync sets a retx flag; the original byte is then resent from bit 0 (SETUP) instead of going to IDLE.
- One frame is 24*BIT_CYC cycles from acceptance to KDAT release, ±1 cycle for the state register.
- Exactly one of SETUP/CLK_LO/CLK_HI owns kclk_oe. kclk_oe is never asserted outside CLK_LO.
- Counter wrap is impossible by construction: CNT_W is sized for HS_TMO_CYC, and it resets on every state change.

Decomposition:
- Shared package amiga_kbd_pkg holds:
  - state enum (IDLE, SETUP, CLK_LO, CLK_HI, WAIT_HS, RESYNC);
  - constants KBD_LOST_SYNC=8'hF9, KBD_INIT_BEGIN=8'hFD, KBD_INIT_END=8'hFE, reserved for the power-up sequencer.
- One sub-module, amiga_kbd_sync: 2-flop synchronizer plus low-run length counter. It outputs hs_ok when a low run of at least HS_MIN_CYC ends.

Test Plan:
- Bench parameters for all scenarios: BIT_CYC=4, HS_MIN_CYC=6, HS_TMO_CYC=200.
- Code 7'h45, key_up=0 -> kdat_oe sampled at each kclk_oe rise reads 1,0,0,0,1,0,1,0 (byte 8'h8A). Exactly 8 kclk pulses, each low 4 cycles. key_ready=0 until handshake.
- After the frame, host holds kdat_in low 8 cycles then releases -> key_ready=1 within 4 cycles; resync_cnt=0.
- Host glitches kdat_in low 3 cycles, then nothing -> glitch ignored. At cycle 200 of WAIT_HS one extra pulse with kdat_oe=1; resync_cnt=1.
- After that resync, host handshakes 8 cycles -> byte 8'h8A retransmitted in full, then a second handshake gives key_ready=1.
- _RES asserted during CLK_LO of bit 3 -> kclk_oe=0, kdat_oe=0 and key_ready=1 asynchronously. After release, no retransmission; a new key_valid is accepted.
- key_valid held with a new code during transmission -> no effect on the current bits. The new code is accepted the cycle after key_ready returns high.
